// File: rtl/dm_arbiter.sv
// Round-robin arbiter and access sequencer in front of the 64 x 32-bit data RAM.
// Partial-byte stores become a read-modify-write; each finished access returns a one-cycle response.
module dm_arbiter (
  input  logic        clk_dm,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [5:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_be,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [5:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_be,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        Mem_Write,
  output logic [5:0]  DM_Addr,
  output logic [31:0] M_W_Data,
  input  logic [31:0] M_R_Data
);

  typedef enum logic [1:0] {IDLE, RD, WR, MW} state_e;

  state_e      state_q;
  logic        last_q;
  logic        port_q;
  logic        we_q;
  logic [5:0]  addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        memWrite_q;
  logic [31:0] wData_q;
  logic        rsp0Valid_q, rsp1Valid_q;
  logic [31:0] rsp0Rdata_q, rsp1Rdata_q;

  logic        grantValid;
  logic        grantPort;
  logic        selWe;
  logic [5:0]  selAddr;
  logic [31:0] selWdata;
  logic [3:0]  selBe;
  logic [31:0] mask;
  logic [31:0] merged_d;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grantValid = 1'b0;
    grantPort  = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grantValid = 1'b1;
        grantPort  = ~last_q;
      end else if (req0_valid) begin
        grantValid = 1'b1;
        grantPort  = 1'b0;
      end else if (req1_valid) begin
        grantValid = 1'b1;
        grantPort  = 1'b1;
      end
    end
  end

  assign selWe    = grantPort ? req1_we    : req0_we;
  assign selAddr  = grantPort ? req1_addr  : req0_addr;
  assign selWdata = grantPort ? req1_wdata : req0_wdata;
  assign selBe    = grantPort ? req1_be    : req0_be;

  assign mask     = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign merged_d = (M_R_Data & ~mask) | (wdata_q & mask);

  assign req0_ready = grantValid & ~grantPort;
  assign req1_ready = grantValid & grantPort;
  assign rsp0_valid = rsp0Valid_q;
  assign rsp1_valid = rsp1Valid_q;
  assign rsp0_rdata = rsp0Rdata_q;
  assign rsp1_rdata = rsp1Rdata_q;
  assign Mem_Write  = memWrite_q;
  assign DM_Addr    = addr_q;
  assign M_W_Data   = wData_q;

  always_ff @(posedge clk_dm) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      memWrite_q  <= 1'b0;
      wData_q     <= '0;
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
      rsp0Rdata_q <= '0;
      rsp1Rdata_q <= '0;
    end else begin
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
      memWrite_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grantValid) begin
            port_q  <= grantPort;
            last_q  <= grantPort;
            we_q    <= selWe;
            addr_q  <= selAddr;
            wdata_q <= selWdata;
            be_q    <= selBe;
            // An all-zero byte mask still completes through WR, just without a RAM write.
            if (selWe && (selBe == 4'hF || selBe == 4'h0)) begin
              state_q    <= WR;
              memWrite_q <= (selBe != 4'h0);
              wData_q    <= selWdata;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          if (we_q) begin
            wData_q    <= merged_d;
            memWrite_q <= 1'b1;
            state_q    <= MW;
          end else begin
            state_q <= IDLE;
            if (port_q) begin
              rsp1Valid_q <= 1'b1;
              rsp1Rdata_q <= M_R_Data;
            end else begin
              rsp0Valid_q <= 1'b1;
              rsp0Rdata_q <= M_R_Data;
            end
          end
        end
        WR, MW: begin
          state_q <= IDLE;
          if (port_q) begin
            rsp1Valid_q <= 1'b1;
            rsp1Rdata_q <= wData_q;
          end else begin
            rsp0Valid_q <= 1'b1;
            rsp0Rdata_q <= wData_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
